pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage PipelineMIPS core. Drives stall*/flush* of every
//  pipeline register (F/D, D/E, E/M, M/W) from cache waits, load-use hazards, the multi-cycle divider,
//  branch mispredicts and exceptions. Also owns the divider latency counter. Sits beside the datapath
//  under the CPU top.
// PARAMETERS
//  DIV_CYCLES   36  cycles a DIV/DIVU occupies E (>=2)
//  CNT_W        32  width of perf counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1  core clock; all state on posedge
//  rst           in   1  asynchronous, active-low reset (0 = reset)
//  i_stall       in   1  icache miss outstanding
//  d_stall       in   1  dcache/uncached access outstanding
//  mem_readE     in   1  load in E
//  reg_writeE    in   5  dest reg of E (0 = none)
//  rsD, rtD      in   5  source regs of D
//  div_startE    in   1  DIV/DIVU valid in E this cycle
//  mispredictM   in   1  branch in M resolved opposite to prediction
//  exceptionM    in   1  precise exception committed in M
//  stallF/D/E/M/W out 1  hold the stage's register
//  flushD/E/M/W  out  1  clear the stage's register (same cycle-wins rule as the regs: flush > stall)
//  div_doneE     out  1  1-cycle pulse: quotient valid, E may advance
//  div_busy      out  1  FSM in DIV state
//  stall_cycles  out CNT_W  cycles with stallF=1 (PERF_CNT_EN)
//  flush_events  out CNT_W  mispredict+exception flushes (PERF_CNT_EN)
// BEHAVIOUR
//  Reset (rst=0): state=RUN, div_cnt=0, all outputs 0, counters 0; release takes effect next edge.
//  FSM states: RUN, DIV. Outputs combinational from state+inputs, evaluated in priority order:
//  1 FREEZE (i_stall|d_stall): stallF..W=1, all flush=0, FSM and div_cnt hold. Exception/mispredict
//    are honoured on first cycle freeze drops (M is held, so inputs stay stable; no latch).
//  2 EXCEPTION (exceptionM): flushD,E,M,W=1, stalls 0; DIV aborted -> RUN, div_cnt=0, no done pulse.
//  3 MISPREDICT (mispredictM): flushD=1 only (delay slot in E survives); in DIV: ignored until done
//    (cannot occur: branch in M implies E not held - assertion).
//  4 DIV state: stallF,D,E=1, flushM=1 (bubble), div_cnt decrements; at div_cnt==0: div_doneE=1,
//    stalls drop, next state RUN.
//  5 RUN & div_startE & ~div_doneE-prev: enter DIV next edge, div_cnt<=DIV_CYCLES-2; this cycle
//    stallF,D,E=1, flushM=1. Total E residency = DIV_CYCLES cycles.
//  6 LOAD-USE (mem_readE & reg_writeE!=0 & (reg_writeE==rsD|reg_writeE==rtD)): stallF,D=1, flushE=1.
//  7 else all 0.
//  - A div whose doneE pulse is issued must not retrigger: div_startE ignored the cycle after DIV exit.
//  - Back-to-back divs: second enters DIV after one RUN cycle.
//  - rst asserted mid-DIV: immediate RUN, outputs 0, no done pulse.
// CONFIGURATION
//  PERF_CNT_EN defined: stall_cycles += stallF each cycle; flush_events += (exceptionM|mispredictM)
//   on non-freeze cycles; wrap at 2^CNT_W; cleared by reset only.
//  Not defined: both ports present, tied to 0, no counter flops.
// STRUCTURE
//  Package pipe_ctrl_pkg: state enum {RUN,DIV}, DIV_CNT_W=$clog2(DIV_CYCLES), priority encoding.
//  Sub-module ctrl_div_counter: load/decrement/zero-flag down-counter, async active-low reset.
// TESTING
//  Reset: rst=0 mid-DIV (cnt=10) -> all outputs 0 same cycle, state RUN after release.
//  Load-use: mem_readE=1, reg_writeE=5, rsD=5 -> stallF=stallD=1, flushE=1 for 1 cycle; reg_writeE=0 -> none.
//  Divide: div_startE pulse, DIV_CYCLES=36 -> stallE=1 for 35 cycles, div_doneE=1 on 36th, flushM each stalled cycle.
//  Freeze inside DIV: d_stall=1 for 4 cycles at cnt=20 -> cnt holds 20, done delayed exactly 4 cycles.
//  Exception vs freeze: exceptionM=1 with i_stall=1 for 3 cycles -> no flush for 3, flushD..W=1 on 4th.
//  Mispredict: mispredictM=1 -> flushD=1, flushE=0; PERF_CNT_EN build: flush_events increments by 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and decode helpers for the pipeline stall/flush sequencer.
//   ctrl_state_e  : sequencer state (RUN, DIV)
//   hazard_e      : winning hazard cause for the current cycle (priority-resolved)
//   ctrl_out_t    : per-stage stall/flush payload plus divider done pulse
package pipe_ctrl_pkg;

  localparam int unsigned DIV_CYCLES_DEF = 36;
  localparam int unsigned CNT_W_DEF      = 32;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DIV = 1'b1
  } ctrl_state_e;

  typedef enum logic [2:0] {
    HZ_NONE       = 3'd0,
    HZ_FREEZE     = 3'd1,
    HZ_EXCEPTION  = 3'd2,
    HZ_DIV        = 3'd3,
    HZ_MISPREDICT = 3'd4,
    HZ_DIV_START  = 3'd5,
    HZ_LOAD_USE   = 3'd6
  } hazard_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
    logic div_done;
  } ctrl_out_t;

  // Width of the divider down-counter for a given E residency.
  function automatic int unsigned div_cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

  // Priority resolution; a mispredict is never acted on while a divide owns E.
  function automatic hazard_e hazard_select(input logic freeze, input logic exception,
                                            input logic mispredict, input logic in_div,
                                            input logic div_start, input logic load_use);
    if (freeze)          return HZ_FREEZE;
    else if (exception)  return HZ_EXCEPTION;
    else if (in_div)     return HZ_DIV;
    else if (mispredict) return HZ_MISPREDICT;
    else if (div_start)  return HZ_DIV_START;
    else if (load_use)   return HZ_LOAD_USE;
    else                 return HZ_NONE;
  endfunction

  // Stall/flush pattern for the winning cause.
  function automatic ctrl_out_t ctrl_decode(input hazard_e hz, input logic div_zero);
    ctrl_out_t o;
    o = '0;
    case (hz)
      HZ_FREEZE: begin
        o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1;
        o.stall_m = 1'b1; o.stall_w = 1'b1;
      end
      HZ_EXCEPTION: begin
        o.flush_d = 1'b1; o.flush_e = 1'b1; o.flush_m = 1'b1; o.flush_w = 1'b1;
      end
      HZ_MISPREDICT: o.flush_d = 1'b1;
      HZ_DIV: begin
        if (div_zero) begin
          o.div_done = 1'b1;
        end else begin
          o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1; o.flush_m = 1'b1;
        end
      end
      HZ_DIV_START: begin
        o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1; o.flush_m = 1'b1;
      end
      HZ_LOAD_USE: begin
        o.stall_f = 1'b1; o.stall_d = 1'b1; o.flush_e = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_div_counter.sv
// Divider latency down-counter: clear > load > decrement > hold.
//   clk, rst (async, active-low) | clr, load, load_val, dec | cnt (registered), zero_c
module ctrl_div_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core plus divider latency tracking.
// Optional feature macro: PERF_CNT_EN (stall/flush performance counters).
//   clk, rst (async, active-low)
//   i_stall, d_stall                     : cache waits, freeze the whole pipe
//   mem_readE, reg_writeE, rsD, rtD      : load-use detection
//   div_startE                           : DIV/DIVU in E
//   mispredictM, exceptionM              : redirect causes in M
//   stallF..W, flushD..W                 : per-register controls (combinational)
//   div_doneE, div_busy                  : divider status
//   stall_cycles, flush_events           : perf counters (0 unless PERF_CNT_EN)
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             mem_readE,
  input  logic [4:0]       reg_writeE,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             div_startE,
  input  logic             mispredictM,
  input  logic             exceptionM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             div_doneE,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned DIV_CNT_W = div_cnt_width(DIV_CYCLES);

  ctrl_state_e          state_q, state_d;
  logic                 done_q, done_d;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 div_zero_c;
  logic                 cnt_clr, cnt_load, cnt_dec;
  logic                 freeze_c, load_use_c, div_start_ok_c;
  hazard_e              hz_c;
  ctrl_out_t            out_c;

  // Hazard detection and output decode; everything is forced low while in reset.
  always_comb begin
    freeze_c       = i_stall | d_stall;
    load_use_c     = mem_readE && (reg_writeE != 5'd0) &&
                     ((reg_writeE == rsD) || (reg_writeE == rtD));
    // The divide that just completed is still visible for one cycle; do not restart it.
    div_start_ok_c = div_startE && !done_q;
    hz_c           = hazard_select(freeze_c, exceptionM, mispredictM,
                                   state_q == ST_DIV, div_start_ok_c, load_use_c);
    out_c          = ctrl_decode(hz_c, div_zero_c);
    if (!rst) out_c = '0;
  end

  // Next state and divider counter control.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (hz_c)
      HZ_FREEZE: ;
      HZ_EXCEPTION: begin
        state_d = ST_RUN;
        cnt_clr = 1'b1;
        done_d  = 1'b0;
      end
      HZ_DIV: begin
        if (div_zero_c) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          done_d  = 1'b0;
        end
      end
      HZ_DIV_START: begin
        state_d  = ST_DIV;
        cnt_load = 1'b1;
        done_d   = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
        done_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Start cycle counts as one of the DIV_CYCLES, and the zero cycle is the done cycle.
  ctrl_div_counter #(.W(DIV_CNT_W)) u_div_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (DIV_CNT_W'(DIV_CYCLES - 2)),
    .dec      (cnt_dec),
    .cnt      (div_cnt),
    .zero_c   (div_zero_c)
  );

  assign stallF    = out_c.stall_f;
  assign stallD    = out_c.stall_d;
  assign stallE    = out_c.stall_e;
  assign stallM    = out_c.stall_m;
  assign stallW    = out_c.stall_w;
  assign flushD    = out_c.flush_d;
  assign flushE    = out_c.flush_e;
  assign flushM    = out_c.flush_m;
  assign flushW    = out_c.flush_w;
  assign div_doneE = out_c.div_done;
  assign div_busy  = (state_q == ST_DIV);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  // Free-running wrap-around perf counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(out_c.stall_f);
      if (!freeze_c && (exceptionM || mispredictM))
        flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

  // A branch resolving in M implies E was not held by a divide.
  mispredict_in_div_a: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == ST_DIV && mispredictM && !freeze_c && !exceptionM));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (default DIV_CYCLES=36, CNT_W=32).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  // Output vector layout: {stallF,D,E,M,W, flushD,E,M,W, div_doneE, div_busy}
  localparam logic [10:0] V_NONE     = 11'b00000_0000_0_0;
  localparam logic [10:0] V_LU       = 11'b11000_0100_0_0;
  localparam logic [10:0] V_FRZ      = 11'b11111_0000_0_0;
  localparam logic [10:0] V_FRZ_BUSY = 11'b11111_0000_0_1;
  localparam logic [10:0] V_DSTART   = 11'b11100_0010_0_0;
  localparam logic [10:0] V_DIV      = 11'b11100_0010_0_1;
  localparam logic [10:0] V_DONE     = 11'b00000_0000_1_1;
  localparam logic [10:0] V_EXC      = 11'b00000_1111_0_0;
  localparam logic [10:0] V_EXC_BUSY = 11'b00000_1111_0_1;
  localparam logic [10:0] V_MISP     = 11'b00000_1000_0_0;

  logic clk, rst;
  logic i_stall, d_stall, mem_readE, div_startE, mispredictM, exceptionM;
  logic [4:0] reg_writeE, rsD, rtD;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW, div_doneE, div_busy;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [10:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] last_exp = '0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  pipeline_hazard_ctrl #(.DIV_CYCLES(36), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
    .mem_readE(mem_readE), .reg_writeE(reg_writeE), .rsD(rsD), .rtD(rtD),
    .div_startE(div_startE), .mispredictM(mispredictM), .exceptionM(exceptionM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_doneE(div_doneE), .div_busy(div_busy),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign obs = {stallF, stallD, stallE, stallM, stallW,
                flushD, flushE, flushM, flushW, div_doneE, div_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [10:0] exp);
    last_exp = exp;
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Advance one clock; the counter model follows the expected outputs of the cycle just ended.
  task automatic tick();
    if (rst) begin
      exp_stall += 32'(last_exp[10]);
      if (!(i_stall || d_stall) && (exceptionM || mispredictM)) exp_flush++;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end
    last_exp = '0;
  endtask

  task automatic check_perf(input string tag);
`ifdef PERF_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, exp_stall);
    check({tag, "_flush_events"}, flush_events, exp_flush);
`else
    check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    check({tag, "_flush_events"}, flush_events, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; i_stall = 1'b1; d_stall = 1'b0; mem_readE = 1'b0;
    reg_writeE = 5'd0; rsD = 5'd0; rtD = 5'd0;
    div_startE = 1'b0; mispredictM = 1'b0; exceptionM = 1'b0;

    // Reset: outputs low even with a freeze request present.
    tick();
    check_out("reset_hold", V_NONE);
    check_perf("reset");
    i_stall = 1'b0; rst = 1'b1;
    tick();
    check_out("idle", V_NONE);
    tick();

    // Load-use via rs, then no-dest, then via rt.
    mem_readE = 1'b1; reg_writeE = 5'd5; rsD = 5'd5; #1;
    check_out("lu_rs", V_LU); tick();
    reg_writeE = 5'd0; #1;
    check_out("lu_r0", V_NONE); tick();
    reg_writeE = 5'd7; rsD = 5'd0; rtD = 5'd7; #1;
    check_out("lu_rt", V_LU); tick();
    mem_readE = 1'b0; reg_writeE = 5'd0; rtD = 5'd0; #1;
    check_out("lu_off", V_NONE); tick();
    check_perf("after_lu");

    // Divide held in E: 35 stalled cycles, done on the 36th, then one ignored cycle.
    div_startE = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      #1;
      check_out($sformatf("div_%0d", n),
                (n == 36) ? V_DONE : ((n == 1) ? V_DSTART : V_DIV));
      tick();
    end
    #1;
    check_out("div_noretrig", V_NONE); tick();

    // Back-to-back divide, frozen for 4 cycles at count 20.
    #1;
    check_out("div2_start", V_DSTART); tick();
    for (int n = 2; n <= 15; n++) begin
      check_out($sformatf("div2_%0d", n), V_DIV); tick();
    end
    d_stall = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("div2_frz_%0d", k), V_FRZ_BUSY); tick();
    end
    d_stall = 1'b0; #1;
    for (int n = 16; n <= 35; n++) begin
      check_out($sformatf("div2_post_%0d", n), V_DIV); tick();
    end
    check_out("div2_done_late", V_DONE);
    div_startE = 1'b0;
    tick();
    check_out("div2_after", V_NONE); tick();
    check_perf("after_div");

    // Exception waits out a freeze, then flushes D..W.
    exceptionM = 1'b1; i_stall = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("exc_frz_%0d", k), V_FRZ); tick();
    end
    i_stall = 1'b0; #1;
    check_out("exc_flush", V_EXC); tick();
    exceptionM = 1'b0; #1;
    check_out("exc_after", V_NONE); tick();

    // Exception aborts a divide: no done pulse afterwards.
    div_startE = 1'b1; #1;
    check_out("abort_start", V_DSTART); tick();
    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("abort_div_%0d", k), V_DIV); tick();
    end
    exceptionM = 1'b1; #1;
    check_out("abort_exc", V_EXC_BUSY);
    tick();
    exceptionM = 1'b0; div_startE = 1'b0; #1;
    check_out("abort_run", V_NONE); tick();
    check_out("abort_nodone", V_NONE); tick();

    // Mispredict flushes D only, and outranks a load-use.
    mispredictM = 1'b1; #1;
    check_out("misp", V_MISP); tick();
    mem_readE = 1'b1; reg_writeE = 5'd3; rsD = 5'd3; #1;
    check_out("misp_over_lu", V_MISP); tick();
    mispredictM = 1'b0; mem_readE = 1'b0; reg_writeE = 5'd0; rsD = 5'd0; #1;
    check_out("misp_after", V_NONE); tick();
    check_perf("after_misp");

    // Reset asserted mid-divide at count 10.
    div_startE = 1'b1; #1;
    check_out("rdiv_start", V_DSTART); tick();
    for (int n = 2; n <= 26; n++) begin
      check_out($sformatf("rdiv_%0d", n), V_DIV);
      if (n < 26) tick();
    end
    rst = 1'b0; #1;
    check_out("rst_mid_div", V_NONE);
    check("rst_mid_div_stall_cycles", stall_cycles, 32'd0);
    check("rst_mid_div_flush_events", flush_events, 32'd0);
    tick();
    rst = 1'b1; div_startE = 1'b0; #1;
    check_out("rst_release", V_NONE); tick();
    check_out("rst_run", V_NONE); tick();
    check_perf("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
